// File: rtl/ibex_csr_wr_arb.sv
// Round-robin write arbiter and write-verify sequencer in front of one shadowed CSR.
// Each granted write is committed, read back and checked, retried on failure, then reported.
module ibex_csr_wr_arb #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned Width      = 32,
  parameter int unsigned MaxRetries = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq*Width-1:0]   wdata_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [NumReq-1:0]         done_o,
  output logic                      resp_err_o,
  output logic                      busy_o,
  output logic                      alert_o,
  input  logic                      alert_clr_i,
  output logic                      csr_wr_en_o,
  output logic [Width-1:0]          csr_wr_data_o,
  input  logic [Width-1:0]          csr_rd_data_i,
  input  logic                      csr_rd_error_i
);

  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned RetryW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StCheck
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [RetryW-1:0]   retry_cnt_q, retry_cnt_d;
  logic [Width-1:0]    data_q, data_d;
  logic                alert_q, alert_d;

  logic                pick_vld;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW:0]       cand;
  logic [Width-1:0]    pick_data;
  logic                check_pass;
  logic                alert_set;
  logic [NumReq-1:0]   gnt_c, done_c;
  logic                resp_err_c, wr_en_c;

  // First requesting index at or after rr_ptr, wrapping modulo NumReq.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
      if (!pick_vld && req_i[cand[IdxW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (pick_idx == IdxW'(k)) pick_data = wdata_i[k*Width +: Width];
    end
  end

  assign check_pass = (csr_rd_data_i == data_q) && !csr_rd_error_i;

  // Next-state and combinational outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    retry_cnt_d = retry_cnt_q;
    data_d      = data_q;
    gnt_c       = '0;
    done_c      = '0;
    resp_err_c  = 1'b0;
    wr_en_c     = 1'b0;
    alert_set   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A read error with no write in flight means the shadow copy diverged at rest.
        alert_set = csr_rd_error_i;
        if (pick_vld) begin
          gnt_c[pick_idx] = 1'b1;
          data_d          = pick_data;
          idx_d           = pick_idx;
          retry_cnt_d     = '0;
          rr_ptr_d        = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + IdxW'(1);
          state_d         = StWrite;
        end
      end
      StWrite: begin
        wr_en_c = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        if (check_pass) begin
          done_c[idx_q] = 1'b1;
          state_d       = StIdle;
        end else if (retry_cnt_q < RetryW'(MaxRetries)) begin
          retry_cnt_d = retry_cnt_q + RetryW'(1);
          state_d     = StWrite;
        end else begin
          done_c[idx_q] = 1'b1;
          resp_err_c    = 1'b1;
          alert_set     = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    alert_d = alert_set | (alert_q & ~alert_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      retry_cnt_q <= '0;
      data_q      <= '0;
      alert_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      retry_cnt_q <= retry_cnt_d;
      data_q      <= data_d;
      alert_q     <= alert_d;
    end
  end

  // Everything is held quiet while reset is asserted.
  assign gnt_o         = rst_i ? '0 : gnt_c;
  assign done_o        = rst_i ? '0 : done_c;
  assign resp_err_o    = !rst_i && resp_err_c;
  assign busy_o        = !rst_i && (state_q != StIdle);
  assign alert_o       = !rst_i && alert_q;
  assign csr_wr_en_o   = !rst_i && wr_en_c;
  assign csr_wr_data_o = rst_i ? '0 : data_q;

endmodule
